// File: rtl/timer_pkg.sv
// Shared constants for the timer block: register map, controller states and
// the TAC clock-select tap table.
package timer_pkg;

   localparam logic [1:0] ADDR_DIV  = 2'd0;
   localparam logic [1:0] ADDR_TIMA = 2'd1;
   localparam logic [1:0] ADDR_TMA  = 2'd2;
   localparam logic [1:0] ADDR_TAC  = 2'd3;

   typedef enum logic {
      ST_RUN = 1'b0,
      ST_OVF = 1'b1
   } state_t;

   // Prescaler bit watched for each TAC[1:0] setting
   localparam int TAP_SEL_00 = 9;
   localparam int TAP_SEL_01 = 3;
   localparam int TAP_SEL_10 = 5;
   localparam int TAP_SEL_11 = 7;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescale counter with DIV clear, TAC tap select and a falling
// edge detector that turns the gated tap bit into single-cycle increment events.
module timer_prescaler
   import timer_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       div_clr,
   input  logic [2:0] tac,
   output logic [7:0] div,
   output logic       inc_evt
);

   logic [CNT_W-1:0] sys_cnt;
   logic             tap_bit;
   logic             timer_in;
   logic             timer_prev;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sys_cnt    <= '0;
         timer_prev <= 1'b0;
      end else begin
         if (div_clr) begin
            sys_cnt <= '0;
         end else if (tick) begin
            sys_cnt <= sys_cnt + 1'b1;
         end
         timer_prev <= timer_in;
      end
   end

   always_comb begin
      tap_bit = sys_cnt[TAP_SEL_00];
      case (tac[1:0])
         2'b00:   tap_bit = sys_cnt[TAP_SEL_00];
         2'b01:   tap_bit = sys_cnt[TAP_SEL_01];
         2'b10:   tap_bit = sys_cnt[TAP_SEL_10];
         default: tap_bit = sys_cnt[TAP_SEL_11];
      endcase
   end

   // Gating before the edge detector makes DIV clears, tap changes and
   // enable clears all count as real falling edges.
   assign timer_in = tac[2] & tap_bit;
   assign inc_evt  = timer_prev & ~timer_in;
   assign div      = sys_cnt[CNT_W-1 -: 8];

endmodule

// File: rtl/timer_controller.sv
// Timer register file (DIV/TIMA/TMA/TAC), overflow/reload sequencer and irq.
//   state | meaning
//   RUN   | TIMA counts on prescaler falling edges
//   OVF   | TIMA wrapped to 00, waiting for next tick to reload from TMA
module timer_controller
   import timer_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       tick,
   input  logic [1:0] addr,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic [7:0] rd_data,
   output logic       irq
);

   state_t      state, state_nxt;
   logic [7:0]  tima, tima_nxt;
   logic [7:0]  tma;
   logic [2:0]  tac;
   logic [7:0]  div;
   logic        inc_evt;
   logic        reload;
   logic        irq_pend;
   logic        wr_div, wr_tima, wr_tma, wr_tac;

   assign wr_div  = wr_en && (addr == ADDR_DIV);
   assign wr_tima = wr_en && (addr == ADDR_TIMA);
   assign wr_tma  = wr_en && (addr == ADDR_TMA);
   assign wr_tac  = wr_en && (addr == ADDR_TAC);

   timer_prescaler #(
      .CNT_W (CNT_W)
   ) u_prescaler (
      .clock   (clock),
      .reset_n (reset_n),
      .tick    (tick),
      .div_clr (wr_div),
      .tac     (tac),
      .div     (div),
      .inc_evt (inc_evt)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_RUN;
         tima     <= 8'h00;
         tma      <= 8'h00;
         tac      <= 3'b000;
         irq_pend <= 1'b0;
         irq      <= 1'b0;
      end else begin
         state    <= state_nxt;
         tima     <= tima_nxt;
         irq_pend <= reload;
         irq      <= irq_pend;
         if (wr_tma) begin
            tma <= wr_data;
         end
         if (wr_tac) begin
            tac <= wr_data[2:0];
         end
      end
   end

   // A CPU write to TIMA always wins; in OVF it also cancels the reload/irq.
   always_comb begin
      state_nxt = state;
      tima_nxt  = tima;
      reload    = 1'b0;
      case (state)
         ST_RUN: begin
            if (wr_tima) begin
               tima_nxt = wr_data;
            end else if (inc_evt) begin
               if (tima == 8'hFF) begin
                  tima_nxt  = 8'h00;
                  state_nxt = ST_OVF;
               end else begin
                  tima_nxt = tima + 8'd1;
               end
            end
         end
         ST_OVF: begin
            if (wr_tima) begin
               tima_nxt  = wr_data;
               state_nxt = ST_RUN;
            end else if (tick) begin
               tima_nxt  = wr_tma ? wr_data : tma;
               reload    = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   always_comb begin
      rd_data = 8'h00;
      case (addr)
         ADDR_DIV:  rd_data = div;
         ADDR_TIMA: rd_data = tima;
         ADDR_TMA:  rd_data = tma;
         default:   rd_data = {5'b11111, tac};
      endcase
   end

endmodule
